// File: rtl/wall_scan_ctrl.sv
// wall_scan_ctrl: per-frame scheduler that runs a single sprite-vs-wall contact
// comparator over every entry of a synchronous wall-table ROM. It snapshots the
// sprite position on start and OR-accumulates a 4-direction collision vector.
// After done pulses, the latched results hold until the next scan completes.
module wall_scan_ctrl #(
    parameter int NUM_WALLS = 32,
    parameter int ADDR_W    = 5,
    parameter int HALF      = 20,
    parameter int BAND      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [9:0]        pos_h_CY,
    input  logic [9:0]        pos_v_CY,
    output logic [ADDR_W-1:0] wall_addr,
    input  logic [9:0]        wall_h,
    input  logic [9:0]        wall_v,
    input  logic              wall_en,
    output logic              busy,
    output logic              done,
    output logic [3:0]        collision,
    output logic              hit,
    output logic [ADDR_W-1:0] first_hit_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WALLS - 1);
    // Contact band: |distance| in [HALF-BAND+1, HALF]
    localparam logic signed [10:0] HALF_S   = 11'(HALF);
    localparam logic signed [10:0] BAND_LO  = 11'(HALF - BAND + 1);

    state_t              state_q;
    logic [9:0]          snap_h_q;
    logic [9:0]          snap_v_q;
    logic [ADDR_W-1:0]   wall_addr_q;
    // Marks that the ROM data on wall_h/wall_v belongs to an address presented
    // in the previous scan cycle (the first SCAN cycle has nothing to evaluate).
    logic                eval_valid_q;
    logic [ADDR_W-1:0]   eval_idx_q;

    logic [3:0]          coll_acc_q, coll_acc_d;
    logic                hit_acc_q, hit_acc_d;
    logic [ADDR_W-1:0]   first_acc_q, first_acc_d;

    logic                busy_q;
    logic                done_q;
    logic [3:0]          collision_q;
    logic                hit_q;
    logic [ADDR_W-1:0]   first_hit_q;

    logic signed [10:0]  dh;
    logic signed [10:0]  dv;
    logic [3:0]          entry_res;

    // Contact comparator: 11-bit signed differences so positions never wrap;
    // the vertical-overlap test wins, so each entry contributes at most one bit.
    always_comb begin
        dh        = $signed({1'b0, snap_h_q}) - $signed({1'b0, wall_h});
        dv        = $signed({1'b0, snap_v_q}) - $signed({1'b0, wall_v});
        entry_res = 4'b0000;
        if (eval_valid_q && wall_en) begin
            if ((dv > -HALF_S) && (dv < HALF_S)) begin
                if ((dh >= BAND_LO) && (dh <= HALF_S)) begin
                    entry_res = 4'b0001;
                end else if ((dh <= -BAND_LO) && (dh >= -HALF_S)) begin
                    entry_res = 4'b0010;
                end
            end else if ((dh > -HALF_S) && (dh < HALF_S)) begin
                if ((dv <= -BAND_LO) && (dv >= -HALF_S)) begin
                    entry_res = 4'b0100;
                end else if ((dv >= BAND_LO) && (dv <= HALF_S)) begin
                    entry_res = 4'b1000;
                end
            end
        end
    end

    // Accumulator next-state: OR in this entry, remember the first contacting index.
    always_comb begin
        coll_acc_d  = coll_acc_q | entry_res;
        hit_acc_d   = hit_acc_q;
        first_acc_d = first_acc_q;
        if (!hit_acc_q && (entry_res != 4'b0000)) begin
            hit_acc_d   = 1'b1;
            first_acc_d = eval_idx_q;
        end
    end

    // Scan FSM with registered outputs: IDLE -> SCAN -> DRAIN -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_h_q     <= '0;
            snap_v_q     <= '0;
            wall_addr_q  <= '0;
            eval_valid_q <= 1'b0;
            eval_idx_q   <= '0;
            coll_acc_q   <= '0;
            hit_acc_q    <= 1'b0;
            first_acc_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            collision_q  <= '0;
            hit_q        <= 1'b0;
            first_hit_q  <= '0;
        end else begin
            done_q       <= 1'b0;
            eval_valid_q <= 1'b0;
            eval_idx_q   <= wall_addr_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_h_q    <= pos_h_CY;
                        snap_v_q    <= pos_v_CY;
                        coll_acc_q  <= '0;
                        hit_acc_q   <= 1'b0;
                        first_acc_q <= '0;
                        wall_addr_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    eval_valid_q <= 1'b1;
                    coll_acc_q   <= coll_acc_d;
                    hit_acc_q    <= hit_acc_d;
                    first_acc_q  <= first_acc_d;
                    if (wall_addr_q == LAST_ADDR) begin
                        state_q <= DRAIN;
                    end else begin
                        wall_addr_q <= wall_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    coll_acc_q  <= coll_acc_d;
                    hit_acc_q   <= hit_acc_d;
                    first_acc_q <= first_acc_d;
                    collision_q <= coll_acc_d;
                    hit_q       <= hit_acc_d;
                    first_hit_q <= first_acc_d;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wall_addr     = wall_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign collision     = collision_q;
    assign hit           = hit_q;
    assign first_hit_idx = first_hit_q;

endmodule
